// File: rtl/vliw_pkg.sv
// Shared types for the VLIW writeback stage.
// Slot order doubles as write priority: higher index wins.
package vliw_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;
  localparam int NSLOT  = 4;
  localparam int NREG   = 1 << REG_AW;

  typedef enum logic [1:0] {
    SLOT_LSU,
    SLOT_IXU1,
    SLOT_IXU2,
    SLOT_BR
  } wb_slot_e;

  typedef struct packed {
    logic              en;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_slot_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOAD,
    COMMIT
  } wb_state_e;
endpackage

// File: rtl/wb_conflict_resolve.sv
// Same-rd arbitration for one captured bundle.
// x0 writes vanish silently; duplicates keep only the top slot.
module wb_conflict_resolve
  import vliw_pkg::*;
(
  input  wb_slot_t [NSLOT-1:0] slot_i,
  output logic     [NSLOT-1:0] en_o,
  output logic                 conflict_o
);

  always_comb begin
    en_o       = '0;
    conflict_o = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (slot_i[i].en && slot_i[i].rd != '0) begin
        en_o[i] = 1'b1;
        for (int j = i + 1; j < NSLOT; j++) begin
          if (slot_i[j].en && slot_i[j].rd == slot_i[i].rd) begin
            en_o[i]    = 1'b0;
            conflict_o = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: holds one VLIW bundle, merges late load data,
// and drives all four register-file write ports in one cycle.
module writeback_stage
  import vliw_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_lsu_en,
  input  logic [REG_AW-1:0] ex_lsu_rd,
  input  logic [XLEN-1:0]   ex_lsu_data,
  input  logic              ex_ixu1_en,
  input  logic [REG_AW-1:0] ex_ixu1_rd,
  input  logic [XLEN-1:0]   ex_ixu1_data,
  input  logic              ex_ixu2_en,
  input  logic [REG_AW-1:0] ex_ixu2_rd,
  input  logic [XLEN-1:0]   ex_ixu2_data,
  input  logic              ex_branch_en,
  input  logic [REG_AW-1:0] ex_branch_rd,
  input  logic [XLEN-1:0]   ex_branch_data,
  input  logic              ex_lsu_pend,
  input  logic              lsu_resp_valid,
  input  logic [XLEN-1:0]   lsu_resp_data,
  output logic              lsu_wr_en,
  output logic [REG_AW-1:0] lsu_rd,
  output logic [XLEN-1:0]   lsu_wr_data,
  output logic              ixu1_wr_en,
  output logic [REG_AW-1:0] ixu1_rd,
  output logic [XLEN-1:0]   ixu1_wr_data,
  output logic              ixu2_wr_en,
  output logic [REG_AW-1:0] ixu2_rd,
  output logic [XLEN-1:0]   ixu2_wr_data,
  output logic              branch_wr_en,
  output logic [REG_AW-1:0] branch_rd,
  output logic [XLEN-1:0]   branch_wr_data,
  output logic [NREG-1:0]   busy_mask,
  output logic              wb_conflict,
  output logic              wb_proto_err,
  output logic [CNT_W-1:0]  retired_count
);

  wb_state_e             state_q, state_d;
  wb_slot_t [NSLOT-1:0]  slot_q, slot_d;
  wb_slot_t [NSLOT-1:0]  port_q, port_d;
  wb_slot_t [NSLOT-1:0]  ex_slot;
  logic     [NSLOT-1:0]  res_en;
  logic                  res_conf;
  logic                  conflict_q, conflict_d;
  logic                  proto_q, proto_d;
  logic     [CNT_W-1:0]  cnt_q, cnt_d;
  logic                  accept;
  logic                  commit_d;

  assign ex_slot[SLOT_LSU]  = '{ex_lsu_en, ex_lsu_rd, ex_lsu_data};
  assign ex_slot[SLOT_IXU1] = '{ex_ixu1_en, ex_ixu1_rd, ex_ixu1_data};
  assign ex_slot[SLOT_IXU2] = '{ex_ixu2_en, ex_ixu2_rd, ex_ixu2_data};
  assign ex_slot[SLOT_BR]   = '{ex_branch_en, ex_branch_rd, ex_branch_data};

  wb_conflict_resolve u_resolve (
    .slot_i     (ex_slot),
    .en_o       (res_en),
    .conflict_o (res_conf)
  );

  assign ex_ready = (state_q != WAIT_LOAD);
  assign accept   = ex_valid & ex_ready;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    conflict_d = conflict_q;
    proto_d    = proto_q;
    unique case (state_q)
      WAIT_LOAD: begin
        if (lsu_resp_valid) begin
          slot_d[SLOT_LSU].data = lsu_resp_data;
          state_d               = COMMIT;
        end
      end
      default: begin
        // Responses are only legal while a load is outstanding
        if (lsu_resp_valid) proto_d = 1'b1;
        if (accept) begin
          for (int i = 0; i < NSLOT; i++) begin
            slot_d[i]    = ex_slot[i];
            slot_d[i].en = res_en[i];
          end
          conflict_d = conflict_q | res_conf;
          state_d    = (ex_lsu_en && ex_lsu_pend) ? WAIT_LOAD : COMMIT;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign commit_d = (state_d == COMMIT);

  // Ports are registered so rd/data hold while a new bundle waits
  always_comb begin
    port_d = port_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < NSLOT; i++) begin
      port_d[i].en = commit_d & slot_d[i].en;
      if (commit_d) begin
        port_d[i].rd   = slot_d[i].rd;
        port_d[i].data = slot_d[i].data;
      end
    end
    if (commit_d) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    busy_mask = '0;
    if (state_q != IDLE) begin
      for (int i = 0; i < NSLOT; i++) begin
        if (slot_q[i].en) busy_mask[slot_q[i].rd] = 1'b1;
      end
    end
    busy_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      port_q     <= '0;
      conflict_q <= 1'b0;
      proto_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      port_q     <= port_d;
      conflict_q <= conflict_d;
      proto_q    <= proto_d;
      cnt_q      <= cnt_d;
    end
  end

  assign lsu_wr_en      = port_q[SLOT_LSU].en;
  assign lsu_rd         = port_q[SLOT_LSU].rd;
  assign lsu_wr_data    = port_q[SLOT_LSU].data;
  assign ixu1_wr_en     = port_q[SLOT_IXU1].en;
  assign ixu1_rd        = port_q[SLOT_IXU1].rd;
  assign ixu1_wr_data   = port_q[SLOT_IXU1].data;
  assign ixu2_wr_en     = port_q[SLOT_IXU2].en;
  assign ixu2_rd        = port_q[SLOT_IXU2].rd;
  assign ixu2_wr_data   = port_q[SLOT_IXU2].data;
  assign branch_wr_en   = port_q[SLOT_BR].en;
  assign branch_rd      = port_q[SLOT_BR].rd;
  assign branch_wr_data = port_q[SLOT_BR].data;
  assign wb_conflict    = conflict_q;
  assign wb_proto_err   = proto_q;
  assign retired_count  = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios then random bundles,
// all checked against a last-writer-wins reference model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        i_en [4];
  logic [4:0]  i_rd [4];
  logic [31:0] i_data [4];
  logic        ex_lsu_pend;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_data;
  logic        o_en [4];
  logic [4:0]  o_rd [4];
  logic [31:0] o_data [4];
  logic [31:0] busy_mask;
  logic        wb_conflict;
  logic        wb_proto_err;
  logic [15:0] retired_count;

  int checks = 0;
  int errors = 0;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_COMMIT = 2;

  int          m_state;
  bit          m_keep [4];
  logic [4:0]  m_rd [4];
  logic [31:0] m_data [4];
  logic [4:0]  m_prd [4];
  logic [31:0] m_pdata [4];
  bit          m_conf;
  bit          m_err;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_lsu_en      (i_en[0]),
    .ex_lsu_rd      (i_rd[0]),
    .ex_lsu_data    (i_data[0]),
    .ex_ixu1_en     (i_en[1]),
    .ex_ixu1_rd     (i_rd[1]),
    .ex_ixu1_data   (i_data[1]),
    .ex_ixu2_en     (i_en[2]),
    .ex_ixu2_rd     (i_rd[2]),
    .ex_ixu2_data   (i_data[2]),
    .ex_branch_en   (i_en[3]),
    .ex_branch_rd   (i_rd[3]),
    .ex_branch_data (i_data[3]),
    .ex_lsu_pend    (ex_lsu_pend),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_data  (lsu_resp_data),
    .lsu_wr_en      (o_en[0]),
    .lsu_rd         (o_rd[0]),
    .lsu_wr_data    (o_data[0]),
    .ixu1_wr_en     (o_en[1]),
    .ixu1_rd        (o_rd[1]),
    .ixu1_wr_data   (o_data[1]),
    .ixu2_wr_en     (o_en[2]),
    .ixu2_rd        (o_rd[2]),
    .ixu2_wr_data   (o_data[2]),
    .branch_wr_en   (o_en[3]),
    .branch_rd      (o_rd[3]),
    .branch_wr_data (o_data[3]),
    .busy_mask      (busy_mask),
    .wb_conflict    (wb_conflict),
    .wb_proto_err   (wb_proto_err),
    .retired_count  (retired_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    ex_valid = 1'b0;
    ex_lsu_pend = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_resp_data = '0;
    for (int s = 0; s < 4; s++) begin
      i_en[s] = 1'b0;
      i_rd[s] = '0;
      i_data[s] = '0;
    end
  endtask

  task automatic set_slot(input int s, input logic [4:0] rd,
                          input logic [31:0] d);
    i_en[s] = 1'b1;
    i_rd[s] = rd;
    i_data[s] = d;
  endtask

  function automatic void model_reset();
    m_state = M_IDLE;
    m_conf = 0;
    m_err = 0;
    m_cnt = '0;
    for (int s = 0; s < 4; s++) begin
      m_keep[s] = 0;
      m_rd[s] = '0;
      m_data[s] = '0;
      m_prd[s] = '0;
      m_pdata[s] = '0;
    end
  endfunction

  // One clock edge of the reference: slots listed in rising
  // priority, so the last slot to claim a register owns it.
  function automatic void model_edge();
    int owner [32];
    if (m_state == M_WAIT) begin
      if (lsu_resp_valid) begin
        m_data[0] = lsu_resp_data;
        m_state = M_COMMIT;
      end
    end else begin
      if (lsu_resp_valid) m_err = 1;
      if (ex_valid) begin
        for (int r = 0; r < 32; r++) owner[r] = -1;
        for (int s = 0; s < 4; s++) begin
          if (i_en[s] && i_rd[s] != 0) begin
            if (owner[i_rd[s]] >= 0) m_conf = 1;
            owner[i_rd[s]] = s;
          end
        end
        for (int s = 0; s < 4; s++) begin
          m_keep[s] = i_en[s] && i_rd[s] != 0 && owner[i_rd[s]] == s;
          m_rd[s] = i_rd[s];
          m_data[s] = i_data[s];
        end
        m_state = (i_en[0] && ex_lsu_pend) ? M_WAIT : M_COMMIT;
      end else begin
        m_state = M_IDLE;
      end
    end
    if (m_state == M_COMMIT) begin
      m_cnt++;
      for (int s = 0; s < 4; s++) begin
        m_prd[s] = m_rd[s];
        m_pdata[s] = m_data[s];
      end
    end
  endfunction

  task automatic compare_all();
    logic [31:0] busy;
    busy = '0;
    if (m_state != M_IDLE)
      for (int s = 0; s < 4; s++)
        if (m_keep[s]) busy[m_rd[s]] = 1'b1;
    chk("ex_ready", 64'(ex_ready), 64'(m_state != M_WAIT));
    chk("busy_mask", 64'(busy_mask), 64'(busy));
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("wr_en%0d", s), 64'(o_en[s]),
          64'(m_state == M_COMMIT && m_keep[s]));
      chk($sformatf("rd%0d", s), 64'(o_rd[s]), 64'(m_prd[s]));
      chk($sformatf("data%0d", s), 64'(o_data[s]), 64'(m_pdata[s]));
    end
    chk("wb_conflict", 64'(wb_conflict), 64'(m_conf));
    chk("wb_proto_err", 64'(wb_proto_err), 64'(m_err));
    chk("retired_count", 64'(retired_count), 64'(m_cnt));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    compare_all();
  endtask

  initial begin
    clear_in();
    rst = 1'b0;
    #2;
    do_reset();
    chk("reset_ready", 64'(ex_ready), 64'd1);

    // 1: two independent writes
    set_slot(1, 5'd5, 32'h11);
    set_slot(2, 5'd6, 32'h22);
    ex_valid = 1'b1;
    tick();
    clear_in();
    chk("t1_busy", 64'(busy_mask), 64'h60);
    chk("t1_ixu1", 64'({o_en[1], o_rd[1]}), 64'({1'b1, 5'd5}));
    chk("t1_ixu2", 64'({o_en[2], o_rd[2]}), 64'({1'b1, 5'd6}));
    chk("t1_cnt", 64'(retired_count), 64'd1);
    tick();

    // 2: late load, 3 wait cycles
    set_slot(0, 5'd7, 32'h0);
    ex_lsu_pend = 1'b1;
    ex_valid = 1'b1;
    tick();
    clear_in();
    for (int k = 0; k < 3; k++) begin
      chk("t2_wait_ready", 64'(ex_ready), 64'd0);
      chk("t2_wait_busy", 64'(busy_mask), 64'h80);
      if (k < 2) tick();
    end
    lsu_resp_valid = 1'b1;
    lsu_resp_data = 32'hDEADBEEF;
    tick();
    clear_in();
    chk("t2_lsu", 64'({o_en[0], o_rd[0], o_data[0]}),
        64'({1'b1, 5'd7, 32'hDEADBEEF}));
    chk("t2_ready", 64'(ex_ready), 64'd1);
    tick();

    // 4: x0 write is dropped, still retires
    set_slot(2, 5'd0, 32'hFF);
    ex_valid = 1'b1;
    tick();
    clear_in();
    chk("t4_en", 64'(o_en[2]), 64'd0);
    chk("t4_conf", 64'(wb_conflict), 64'd0);
    chk("t4_cnt", 64'(retired_count), 64'd3);
    tick();

    // 3: triple conflict on rd 9
    set_slot(0, 5'd9, 32'h1);
    set_slot(1, 5'd9, 32'h2);
    set_slot(3, 5'd9, 32'h3);
    ex_valid = 1'b1;
    tick();
    clear_in();
    chk("t3_br", 64'({o_en[3], o_data[3]}), 64'({1'b1, 32'h3}));
    chk("t3_lo", 64'({o_en[0], o_en[1]}), 64'd0);
    chk("t3_conf", 64'(wb_conflict), 64'd1);
    tick();
    tick();
    chk("t3_sticky", 64'(wb_conflict), 64'd1);

    // 5: four back-to-back bundles
    for (int k = 0; k < 4; k++) begin
      clear_in();
      set_slot(k, 5'(10 + k), 32'(100 + k));
      ex_valid = 1'b1;
      tick();
      chk("t5_en", 64'(o_en[k]), 64'd1);
      chk("t5_ready", 64'(ex_ready), 64'd1);
    end
    clear_in();
    tick();

    // 6: reset while waiting for a load, then stray response
    set_slot(0, 5'd4, 32'h0);
    ex_lsu_pend = 1'b1;
    ex_valid = 1'b1;
    tick();
    clear_in();
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    lsu_resp_valid = 1'b1;
    lsu_resp_data = 32'h5555;
    tick();
    clear_in();
    chk("t6_err", 64'(wb_proto_err), 64'd1);
    chk("t6_lsu_en", 64'(o_en[0]), 64'd0);
    chk("t6_idle", 64'({ex_ready, busy_mask}), 64'({1'b1, 32'h0}));
    tick();

    // random bundles, small rd range to force conflicts
    do_reset();
    for (int n = 0; n < 500; n++) begin
      clear_in();
      ex_valid = ($urandom % 4) != 0;
      for (int s = 0; s < 4; s++) begin
        i_en[s] = ($urandom % 3) != 0;
        i_rd[s] = 5'($urandom_range(0, 7));
        i_data[s] = $urandom;
      end
      ex_lsu_pend = ($urandom % 3) == 0;
      lsu_resp_data = $urandom;
      if (m_state == M_WAIT) lsu_resp_valid = ($urandom % 3) == 0;
      else lsu_resp_valid = ($urandom % 40) == 0;
      tick();
    end
    clear_in();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
